// File: rtl/rf_port_ctrl.sv
// Register-file port controller: sequences READ/WRITE/SWAP/CLEAR commands onto a 4x8 register file.
// Optional SWAP datapath is built only when RF_PORT_CTRL_SWAP_EN is defined.
module rf_port_ctrl #(
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] reg1,
  output logic [1:0] reg2,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [1:0] regw,
  output logic [7:0] dataw,
  output logic       RFWrite,
  output logic       busy,
  output logic [2:0] dbg_state
);

  // Handshakes: a command transfers on a rising edge with cmd_valid && cmd_ready;
  // a response transfers on a rising edge with rsp_valid && rsp_ready.
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    CLR  = 3'd3,
    RESP = 3'd4
`ifdef RF_PORT_CTRL_SWAP_EN
    , SW_CAP = 3'd5,
    SW_WA  = 3'd6,
    SW_WB  = 3'd7
`endif
  } state_t;

  state_t     state;
  logic [1:0] counter;
  logic [1:0] lat_ra;
  logic [7:0] lat_data;
`ifdef RF_PORT_CTRL_SWAP_EN
  logic [1:0] lat_rb;
  logic [7:0] tmpa;
  logic [7:0] tmpb;
`else
  logic unused_swap_inputs;
  assign unused_swap_inputs = &{1'b0, cmd_rb, data2};
`endif

  assign dbg_state = state;

  // All outputs are registered: each transition loads the values the next state drives.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= 2'd0;
      lat_ra    <= 2'd0;
      lat_data  <= 8'h00;
`ifdef RF_PORT_CTRL_SWAP_EN
      lat_rb    <= 2'd0;
      tmpa      <= 8'h00;
      tmpb      <= 8'h00;
`endif
      rsp_data  <= 8'h00;
      rsp_valid <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      RFWrite   <= 1'b0;
      reg1      <= 2'd0;
      reg2      <= 2'd0;
      regw      <= 2'd0;
      dataw     <= 8'h00;
    end else begin
      RFWrite <= 1'b0;
      reg1    <= 2'd0;
      reg2    <= 2'd0;
      regw    <= 2'd0;
      dataw   <= 8'h00;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_ra    <= cmd_ra;
            lat_data  <= cmd_data;
`ifdef RF_PORT_CTRL_SWAP_EN
            lat_rb    <= cmd_rb;
`endif
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (cmd_op)
              OP_READ: begin
                state <= RD;
                reg1  <= cmd_ra;
              end
              OP_WRITE: begin
                state   <= WR;
                RFWrite <= 1'b1;
                regw    <= cmd_ra;
                dataw   <= cmd_data;
              end
              OP_SWAP: begin
`ifdef RF_PORT_CTRL_SWAP_EN
                state <= SW_CAP;
                reg1  <= cmd_ra;
                reg2  <= cmd_rb;
`else
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= 8'hFF;
`endif
              end
              OP_CLEAR: begin
                state   <= CLR;
                counter <= 2'd0;
                RFWrite <= 1'b1;
                regw    <= 2'd0;
                dataw   <= CLEAR_VAL;
              end
              default: state <= IDLE;
            endcase
          end
        end
        RD: begin
          rsp_data  <= data1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        WR: begin
          rsp_data  <= lat_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
`ifdef RF_PORT_CTRL_SWAP_EN
        SW_CAP: begin
          tmpa    <= data1;
          tmpb    <= data2;
          state   <= SW_WA;
          RFWrite <= 1'b1;
          regw    <= lat_ra;
          dataw   <= data2;
        end
        SW_WA: begin
          state   <= SW_WB;
          RFWrite <= 1'b1;
          regw    <= lat_rb;
          dataw   <= tmpa;
        end
        SW_WB: begin
          rsp_data  <= tmpa;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
`endif
        CLR: begin
          // counter names the register being written in the current cycle
          if (counter == 2'd3) begin
            rsp_data  <= CLEAR_VAL;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            counter <= counter + 2'd1;
            RFWrite <= 1'b1;
            regw    <= counter + 2'd1;
            dataw   <= CLEAR_VAL;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rf_port_ctrl.md
RF_PORT_CTRL -- requirements
Module: rf_port_ctrl

Interface
REQ-001 Parameter CLEAR_VAL, default 8'h00: value written to every register by a CLEAR command.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising edge of clock.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  controller accepts command this cycle.
REQ-006 cmd_op  in  2  00 READ, 01 WRITE, 10 SWAP, 11 CLEAR.
REQ-007 cmd_ra  in  2  primary register index.
REQ-008 cmd_rb  in  2  secondary register index (SWAP only).
REQ-009 cmd_data  in  8  write data (WRITE only).
REQ-010 rsp_valid  out  1  response present.
REQ-011 rsp_ready  in  1  response consumed this cycle.
REQ-012 rsp_data  out  8  response payload.
REQ-013 reg1, reg2  out  2 each  register-file read selects.
REQ-014 data1, data2  in  8 each  register-file asynchronous read data for reg1/reg2.
REQ-015 regw  out  2  register-file write select.
REQ-016 dataw  out  8  register-file write data.
REQ-017 RFWrite  out  1  register-file write enable; the write takes effect at the next rising clock edge.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR, SW_CAP, SW_WA, SW_WB, CLR, RESP.
REQ-020 cmd_ready SHALL equal 1 only in IDLE; a command transfers when cmd_valid and cmd_ready are both 1 at a rising edge, and cmd_ra, cmd_rb, cmd_op and cmd_data SHALL be latched at that edge.
REQ-021 READ: IDLE->RD; in RD, reg1=ra; at the end of RD, rsp_data<=data1; RD->RESP.
REQ-022 WRITE: IDLE->WR; in WR, RFWrite=1, regw=ra, dataw=latched data; rsp_data<=latched data; WR->RESP.
REQ-023 SWAP: SW_CAP drives reg1=ra, reg2=rb and captures tmpa<=data1, tmpb<=data2.
REQ-024 SWAP continued: SW_WA writes tmpb to ra; SW_WB writes tmpa to rb; rsp_data<=tmpa; then ->RESP.
REQ-025 SWAP with ra==rb SHALL execute all three states and leave the register unchanged.
REQ-026 CLEAR: a 2-bit counter starts at 0; each CLR cycle writes CLEAR_VAL to regw=counter; after counter==3, CLR->RESP with rsp_data=CLEAR_VAL (4 write cycles total).
REQ-027 RFWrite SHALL be 1 only in WR, SW_WA, SW_WB and CLR, and at most one register SHALL be written per cycle.
REQ-028 In RESP, rsp_valid=1 and rsp_data SHALL be held stable until rsp_ready=1; RESP->IDLE on the handshake edge.
REQ-029 rsp_ready held high in RESP SHALL give exactly one rsp_valid cycle; back-to-back commands SHALL be accepted no earlier than the cycle after RESP exits.
REQ-030 Command-to-rsp_valid latency: READ and WRITE 2 cycles, SWAP 4 cycles, CLEAR 5 cycles.
REQ-031 reg1, reg2, regw and dataw SHALL be 0 whenever they are not used by the current state.

Reset
REQ-032 When reset=1 at a rising edge: state<=IDLE, counter<=0, tmpa<=0, tmpb<=0, rsp_data<=0.
REQ-033 After reset: rsp_valid=0, RFWrite=0, busy=0, cmd_ready=1 (from the cycle following reset deassertion).
REQ-034 Reset mid-operation SHALL abort the operation and drop any pending response; writes already performed SHALL persist.
REQ-035 Reset SHALL take priority over a command handshake in the same cycle.

Configuration
REQ-036 Macro RF_PORT_CTRL_SWAP_EN SHALL gate the SWAP operation.
REQ-037 With RF_PORT_CTRL_SWAP_EN defined, SWAP SHALL operate as specified in REQ-023 to REQ-025.
REQ-038 Without RF_PORT_CTRL_SWAP_EN, states SW_CAP, SW_WA and SW_WB SHALL be absent.
REQ-039 Without RF_PORT_CTRL_SWAP_EN, op 10 SHALL go IDLE->RESP with rsp_data=8'hFF and no register write.

Verification
REQ-040 WRITE ra=2, data=8'h5A, then READ ra=2 -> RFWrite for exactly one cycle with regw=2; READ returns rsp_data=8'h5A 2 cycles after acceptance.
REQ-041 r1=8'h11 and r3=8'h33, SWAP ra=1 rb=3 -> r1=8'h33, r3=8'h11, rsp_data=8'h11, rsp_valid 4 cycles after acceptance.
REQ-042 CLEAR with CLEAR_VAL=8'hA5 -> regw sequence 0,1,2,3 on 4 consecutive cycles with dataw=8'hA5; rsp_data=8'hA5.
REQ-043 Hold rsp_ready=0 for 3 cycles during RESP -> rsp_valid and rsp_data stay stable; cmd_ready stays 0; a new cmd_valid is not accepted.
REQ-044 Assert reset during CLR with counter=1 -> r0 and r1 hold CLEAR_VAL; r2 and r3 are unchanged; no rsp_valid; next cycle busy=0, cmd_ready=1.
REQ-045 Build without RF_PORT_CTRL_SWAP_EN, issue op 10 -> rsp_data=8'hFF after 1 cycle; RFWrite never asserted.
